// File: rtl/ram_rd_arbiter_if.sv
// Request/grant, RAM read port and tagged-response bundle for ram_rd_arbiter.
// The master side is the client/RAM environment, and the slave side is the arbiter.
interface ram_rd_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 8,
    parameter int SIZE_DATA = 8,
    parameter int ID_W      = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0]        gnt;
    logic                      ram_rd_en;
    logic [ADDR_W-1:0]         ram_addr;
    logic [SIZE_DATA-1:0]      ram_data;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [SIZE_DATA-1:0]      rsp_data;
    logic                      busy;

    modport master (
        output req, addr, ram_data,
        input  gnt, ram_rd_en, ram_addr, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req, addr, ram_data,
        output gnt, ram_rd_en, ram_addr, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/ram_rd_arbiter.sv
// Round-robin arbiter that shares one synchronous-read RAM port among NUM_REQ clients.
// It returns each read's data tagged with the requester ID after a fixed latency.
module ram_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 8,
    parameter int SIZE_DATA  = 8,
    parameter int RD_LATENCY = 2,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input logic            i_clk,
    input logic            i_rst,
    ram_rd_arbiter_if.slave bus
);

    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      ptr_next;
    logic [ID_W-1:0]      gnt_id;
    logic [ID_W-1:0]      issue_id;
    logic [ID_W:0]        cand;
    logic [NUM_REQ-1:0]   gnt;
    logic                 gnt_any;
    logic [ADDR_W-1:0]    sel_addr;
    logic                 rd_en;
    logic [ADDR_W-1:0]    ram_addr;
    logic [RD_LATENCY:0]  tag_valid;
    logic [ID_W-1:0]      tag_id [RD_LATENCY+1];
    logic [SIZE_DATA-1:0] rsp_data;

    // Scan from the pointer with one extra bit, so that the wrap needs only a single subtract.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        if (!i_rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cand = {1'b0, ptr} + (ID_W+1)'(i);
                if (cand >= (ID_W+1)'(NUM_REQ)) begin
                    cand = cand - (ID_W+1)'(NUM_REQ);
                end
                if (!gnt_any && bus.req[cand[ID_W-1:0]]) begin
                    gnt[cand[ID_W-1:0]] = 1'b1;
                    gnt_any             = 1'b1;
                    gnt_id              = cand[ID_W-1:0];
                end
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == ID_W'(k)) begin
                sel_addr = bus.addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign ptr_next = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr      <= '0;
            rd_en    <= 1'b0;
            ram_addr <= '0;
            issue_id <= '0;
        end else begin
            rd_en <= gnt_any;
            if (gnt_any) begin
                ptr      <= ptr_next;
                ram_addr <= sel_addr;
                issue_id <= gnt_id;
            end
        end
    end

    // The last stage doubles as the response register and holds its ID between pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tag_valid <= '0;
            rsp_data  <= '0;
            for (int unsigned j = 0; j <= RD_LATENCY; j++) begin
                tag_id[j] <= '0;
            end
        end else begin
            tag_valid <= {tag_valid[RD_LATENCY-1:0], rd_en};
            tag_id[0] <= issue_id;
            for (int unsigned j = 1; j < RD_LATENCY; j++) begin
                tag_id[j] <= tag_id[j-1];
            end
            if (tag_valid[RD_LATENCY-1]) begin
                tag_id[RD_LATENCY] <= tag_id[RD_LATENCY-1];
                rsp_data           <= bus.ram_data;
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.ram_rd_en = rd_en;
    assign bus.ram_addr  = ram_addr;
    assign bus.rsp_valid = tag_valid[RD_LATENCY];
    assign bus.rsp_id    = tag_id[RD_LATENCY];
    assign bus.rsp_data  = rsp_data;
    assign bus.busy      = rd_en | (|tag_valid);

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Directed bench for ram_rd_arbiter: one default build and one RD_LATENCY=4 build.
// The RAM behind each build returns addr ^ 8'h99.
module tb_ram_rd_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    ram_rd_arbiter_if #(.NUM_REQ(4), .ADDR_W(8), .SIZE_DATA(8)) bus ();
    ram_rd_arbiter_if #(.NUM_REQ(4), .ADDR_W(8), .SIZE_DATA(8)) bus4 ();

    ram_rd_arbiter #(.NUM_REQ(4), .ADDR_W(8), .SIZE_DATA(8), .RD_LATENCY(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    ram_rd_arbiter #(.NUM_REQ(4), .ADDR_W(8), .SIZE_DATA(8), .RD_LATENCY(4)) dut4 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    // RAM models are unaffected by reset, so data still returns after a mid-flight reset.
    logic [1:0] v2 = '0;
    logic [7:0] a2 [2];
    always @(posedge clk) begin
        v2    <= {v2[0], bus.ram_rd_en};
        a2[0] <= bus.ram_addr;
        a2[1] <= a2[0];
    end
    assign bus.ram_data = v2[1] ? (a2[1] ^ 8'h99) : 8'hF0;

    logic [3:0] v4 = '0;
    logic [7:0] a4 [4];
    always @(posedge clk) begin
        v4    <= {v4[2:0], bus4.ram_rd_en};
        a4[0] <= bus4.ram_addr;
        for (int i = 1; i < 4; i++) a4[i] <= a4[i-1];
    end
    assign bus4.ram_data = v4[3] ? (a4[3] ^ 8'h99) : 8'hF0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'hF;
        @(negedge clk);
        vectors++; if (bus.gnt !== 4'h0) begin miscompares++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
        next_cycle();
        rst = 1'b0;
        bus.req = 4'h0;
        @(negedge clk);
        vectors++; if (bus.ram_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b want 0", bus.ram_rd_en); end
        vectors++; if (bus.ram_addr !== 8'h00) begin miscompares++; $display("FAIL reset_ram_addr: got %h want 00", bus.ram_addr); end
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        vectors++; if (bus.rsp_id !== 2'd0) begin miscompares++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
        vectors++; if (bus.rsp_data !== 8'h00) begin miscompares++; $display("FAIL reset_rsp_data: got %h want 00", bus.rsp_data); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vectors++; if (bus4.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy4: got %b want 0", bus4.busy); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        logic [1:0] ei;
        logic [7:0] ed;
        bus.addr = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int t = 0; t <= 12; t++) begin
            bus.req = (t < 8) ? 4'hF : 4'h0;
            @(negedge clk);
            eg = (t < 8) ? 4'(1 << (t % 4)) : 4'h0;
            vectors++; if (bus.gnt !== eg) begin miscompares++; $display("FAIL rr_gnt t=%0d: got %b want %b", t, bus.gnt, eg); end
            if (t >= 4 && t < 12) begin
                ei = 2'((t - 4) % 4);
                ed = (8'h10 + 8'((t - 4) % 4)) ^ 8'h99;
                vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rr_valid t=%0d: got %b want 1", t, bus.rsp_valid); end
                vectors++; if (bus.rsp_id !== ei) begin miscompares++; $display("FAIL rr_id t=%0d: got %0d want %0d", t, bus.rsp_id, ei); end
                vectors++; if (bus.rsp_data !== ed) begin miscompares++; $display("FAIL rr_data t=%0d: got %h want %h", t, bus.rsp_data, ed); end
            end else begin
                vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rr_valid t=%0d: got %b want 0", t, bus.rsp_valid); end
            end
            if (t == 12) begin
                vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rr_busy_idle: got %b want 0", bus.busy); end
            end
            next_cycle();
        end
    endtask

    task automatic test_single();
        bus.addr[2*8 +: 8] = 8'h3C;
        for (int t = 0; t <= 6; t++) begin
            bus.req = (t == 0) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            if (t == 0) begin
                vectors++; if (bus.gnt !== 4'b0100) begin miscompares++; $display("FAIL single_gnt: got %b want 0100", bus.gnt); end
            end
            if (t == 1) begin
                vectors++; if (bus.ram_rd_en !== 1'b1) begin miscompares++; $display("FAIL single_rd_en: got %b want 1", bus.ram_rd_en); end
                vectors++; if (bus.ram_addr !== 8'h3C) begin miscompares++; $display("FAIL single_ram_addr: got %h want 3c", bus.ram_addr); end
            end
            if (t == 2) begin
                vectors++; if (bus.ram_rd_en !== 1'b0) begin miscompares++; $display("FAIL single_rd_en_off: got %b want 0", bus.ram_rd_en); end
                vectors++; if (bus.ram_addr !== 8'h3C) begin miscompares++; $display("FAIL single_addr_hold: got %h want 3c", bus.ram_addr); end
            end
            vectors++; if (bus.rsp_valid !== (t == 4)) begin miscompares++; $display("FAIL single_valid t=%0d: got %b want %b", t, bus.rsp_valid, (t == 4)); end
            if (t == 4) begin
                vectors++; if (bus.rsp_id !== 2'd2) begin miscompares++; $display("FAIL single_id: got %0d want 2", bus.rsp_id); end
            end
            if (t >= 4) begin
                vectors++; if (bus.rsp_data !== 8'hA5) begin miscompares++; $display("FAIL single_data t=%0d: got %h want a5", t, bus.rsp_data); end
            end
            next_cycle();
        end
    endtask

    task automatic test_wrap();
        logic [3:0] eg;
        bus.addr[3*8 +: 8] = 8'h77;
        for (int t = 0; t <= 7; t++) begin
            bus.req = (t == 0) ? 4'b1000 : (t <= 2) ? 4'b1001 : 4'b0000;
            @(negedge clk);
            eg = (t == 0) ? 4'b1000 : (t == 1) ? 4'b0001 : (t == 2) ? 4'b1000 : 4'b0000;
            vectors++; if (bus.gnt !== eg) begin miscompares++; $display("FAIL wrap_gnt t=%0d: got %b want %b", t, bus.gnt, eg); end
            vectors++; if (bus.rsp_valid !== (t >= 4 && t <= 6)) begin miscompares++; $display("FAIL wrap_valid t=%0d: got %b", t, bus.rsp_valid); end
            if (t == 4 || t == 6) begin
                vectors++; if (bus.rsp_id !== 2'd3 || bus.rsp_data !== 8'hEE) begin miscompares++; $display("FAIL wrap_rsp t=%0d: got id %0d data %h want id 3 data ee", t, bus.rsp_id, bus.rsp_data); end
            end
            if (t == 5) begin
                vectors++; if (bus.rsp_id !== 2'd0 || bus.rsp_data !== 8'h89) begin miscompares++; $display("FAIL wrap_rsp t=5: got id %0d data %h want id 0 data 89", bus.rsp_id, bus.rsp_data); end
            end
            next_cycle();
        end
    endtask

    task automatic test_drop();
        logic [3:0] eg;
        for (int t = 0; t <= 6; t++) begin
            bus.req = (t == 0) ? 4'b0110 : (t == 1) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            eg = (t == 0) ? 4'b0010 : (t == 1) ? 4'b0001 : 4'b0000;
            vectors++; if (bus.gnt !== eg) begin miscompares++; $display("FAIL drop_gnt t=%0d: got %b want %b", t, bus.gnt, eg); end
            vectors++; if (bus.rsp_valid !== (t == 4 || t == 5)) begin miscompares++; $display("FAIL drop_valid t=%0d: got %b", t, bus.rsp_valid); end
            if (t == 4) begin
                vectors++; if (bus.rsp_id !== 2'd1 || bus.rsp_data !== 8'h88) begin miscompares++; $display("FAIL drop_rsp t=4: got id %0d data %h want id 1 data 88", bus.rsp_id, bus.rsp_data); end
            end
            if (t == 5) begin
                vectors++; if (bus.rsp_id !== 2'd0 || bus.rsp_data !== 8'h89) begin miscompares++; $display("FAIL drop_rsp t=5: got id %0d data %h want id 0 data 89", bus.rsp_id, bus.rsp_data); end
            end
            next_cycle();
        end
    endtask

    task automatic test_only_one();
        bus.addr[1*8 +: 8] = 8'h55;
        for (int t = 0; t <= 9; t++) begin
            bus.req = (t < 5) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            vectors++; if (bus.gnt !== ((t < 5) ? 4'b0010 : 4'b0000)) begin miscompares++; $display("FAIL one_gnt t=%0d: got %b", t, bus.gnt); end
            vectors++; if (bus.ram_rd_en !== (t >= 1 && t <= 5)) begin miscompares++; $display("FAIL one_rd_en t=%0d: got %b", t, bus.ram_rd_en); end
            vectors++; if (bus.busy !== (t >= 1 && t <= 8)) begin miscompares++; $display("FAIL one_busy t=%0d: got %b want %b", t, bus.busy, (t >= 1 && t <= 8)); end
            vectors++; if (bus.rsp_valid !== (t >= 4 && t <= 8)) begin miscompares++; $display("FAIL one_valid t=%0d: got %b", t, bus.rsp_valid); end
            if (t >= 4 && t <= 8) begin
                vectors++; if (bus.rsp_id !== 2'd1 || bus.rsp_data !== 8'hCC) begin miscompares++; $display("FAIL one_rsp t=%0d: got id %0d data %h want id 1 data cc", t, bus.rsp_id, bus.rsp_data); end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_midflight();
        logic [3:0] eg;
        for (int t = 0; t <= 14; t++) begin
            rst = (t == 3);
            bus.req = (t <= 2) ? 4'b0111 : (t == 3) ? 4'b1111 : (t == 10) ? 4'b1010 : 4'b0000;
            @(negedge clk);
            eg = (t == 0) ? 4'b0100 : (t == 1) ? 4'b0001 : (t == 2) ? 4'b0010 : (t == 10) ? 4'b0010 : 4'b0000;
            vectors++; if (bus.gnt !== eg) begin miscompares++; $display("FAIL mid_gnt t=%0d: got %b want %b", t, bus.gnt, eg); end
            if (t >= 3) begin
                vectors++; if (bus.rsp_valid !== (t == 14)) begin miscompares++; $display("FAIL mid_valid t=%0d: got %b want %b", t, bus.rsp_valid, (t == 14)); end
            end
            if (t == 4) begin
                vectors++; if (bus.busy !== 1'b0 || bus.ram_rd_en !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got busy %b rd_en %b want 0 0", bus.busy, bus.ram_rd_en); end
                vectors++; if (bus.rsp_id !== 2'd0 || bus.rsp_data !== 8'h00) begin miscompares++; $display("FAIL mid_rsp_clear: got id %0d data %h want 0 00", bus.rsp_id, bus.rsp_data); end
            end
            if (t == 14) begin
                vectors++; if (bus.rsp_id !== 2'd1 || bus.rsp_data !== 8'hCC) begin miscompares++; $display("FAIL mid_rsp: got id %0d data %h want id 1 data cc", bus.rsp_id, bus.rsp_data); end
            end
            next_cycle();
        end
        rst = 1'b0;
    endtask

    task automatic test_latency4();
        bus4.addr[0 +: 8] = 8'h20;
        for (int t = 0; t <= 8; t++) begin
            bus4.req = (t == 0) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            if (t == 0) begin
                vectors++; if (bus4.gnt !== 4'b0001) begin miscompares++; $display("FAIL lat4_gnt: got %b want 0001", bus4.gnt); end
            end
            vectors++; if (bus4.rsp_valid !== (t == 6)) begin miscompares++; $display("FAIL lat4_valid t=%0d: got %b want %b", t, bus4.rsp_valid, (t == 6)); end
            if (t == 6) begin
                vectors++; if (bus4.rsp_id !== 2'd0 || bus4.rsp_data !== 8'hB9) begin miscompares++; $display("FAIL lat4_rsp: got id %0d data %h want id 0 data b9", bus4.rsp_id, bus4.rsp_data); end
            end
            next_cycle();
        end
    endtask

    initial begin
        bus.req   = '0;
        bus.addr  = '0;
        bus4.req  = '0;
        bus4.addr = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_drop();
        test_only_one();
        test_reset_midflight();
        test_latency4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
